acia_tx: RTL and testbench



---
 rtl/acia_pkg.sv | 15 +
 rtl/acia_tx_if.sv | 21 ++
 rtl/acia_tx_fifo.sv | 53 +++++
 rtl/acia_tx.sv | 148 ++++++++++++++
 tb/tb_acia_tx.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/acia_pkg.sv
// rtl/acia_pkg.sv - shared ACIA state encoding and line constants (transmitter and receiver)
package acia_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } acia_state_e;

  localparam int   DATA_BITS = 8;
  localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/acia_tx_if.sv
// rtl/acia_tx_if.sv - byte strobe and serial status bundle for the ACIA transmitter
interface acia_tx_if;

  logic [7:0] tx_dat;
  logic       tx_stb;
  logic       tx_serial;
  logic       tx_busy;
  logic       tx_full;
  logic       tx_err;

  modport master (
    output tx_dat, tx_stb,
    input  tx_serial, tx_busy, tx_full, tx_err
  );

  modport slave (
    input  tx_dat, tx_stb,
    output tx_serial, tx_busy, tx_full, tx_err
  );

endinterface

// File: rtl/acia_tx_fifo.sv
// rtl/acia_tx_fifo.sv - DEPTH x 8 byte FIFO with extra-bit pointers for full/empty
module acia_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_push,
  input  logic [7:0] i_dat,
  input  logic       i_pop,
  output logic [7:0] o_dat,
  output logic       o_full,
  output logic       o_empty,
  output logic       o_empty_nxt
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic [7:0]  r_mem [DEPTH];
  logic [AW:0] w_count;
  logic [AW:0] w_count_nxt;
  logic        w_wr;
  logic        w_rd;

  // Occupancy from the registered pointers, so full is judged before any same-cycle pop
  assign w_count     = r_wr_ptr - r_rd_ptr;
  assign o_full      = (w_count == FULL_CNT);
  assign o_empty     = (w_count == '0);
  assign w_wr        = i_push & ~o_full;
  assign w_rd        = i_pop & ~o_empty;
  assign w_count_nxt = w_count + {{AW{1'b0}}, w_wr} - {{AW{1'b0}}, w_rd};
  assign o_empty_nxt = (w_count_nxt == '0);
  assign o_dat       = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update; a reset discards any queued bytes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage array, written only when a slot is free
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_dat;
  end

endmodule

// File: rtl/acia_tx.sv
// rtl/acia_tx.sv - 8N1 UART transmitter with byte FIFO; ACIA_TX_PARITY_EN adds an even parity bit
module acia_tx
  import acia_pkg::*;
#(
  parameter int SCW     = 16,
  parameter int sym_cnt = 40000,
  parameter int DEPTH   = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  acia_tx_if.slave bus
);

  localparam logic [SCW-1:0] BAUD_LAST = SCW'(sym_cnt - 1);
  localparam logic [2:0]     LAST_BIT  = 3'(DATA_BITS - 1);

  acia_state_e    r_state;
  acia_state_e    w_state_nxt;
  logic [SCW-1:0] r_baud;
  logic [7:0]     r_shift;
  logic [2:0]     r_bit_idx;
  logic           r_tx_serial;
  logic           r_busy;
  logic           r_err;
  logic [7:0]     w_fifo_dat;
  logic           w_full;
  logic           w_empty;
  logic           w_empty_nxt;
  logic           w_pop;
  logic           w_line;
  logic           w_bit_end;
`ifdef ACIA_TX_PARITY_EN
  logic           r_parity;
`endif

  acia_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (bus.tx_stb),
    .i_dat       (bus.tx_dat),
    .i_pop       (w_pop),
    .o_dat       (w_fifo_dat),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_empty_nxt (w_empty_nxt)
  );

  assign w_bit_end     = (r_baud == BAUD_LAST);
  assign bus.tx_serial = r_tx_serial;
  assign bus.tx_busy   = r_busy;
  assign bus.tx_full   = w_full;
  assign bus.tx_err    = r_err;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state, FIFO pop and the line level for the current bit
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_line      = LINE_IDLE;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = START;
        end
      end
      START: begin
        w_line = 1'b0;
        if (w_bit_end) w_state_nxt = DATA;
      end
      DATA: begin
        w_line = r_shift[0];
        if (w_bit_end && (r_bit_idx == LAST_BIT)) begin
`ifdef ACIA_TX_PARITY_EN
          w_state_nxt = PARITY;
`else
          w_state_nxt = STOP;
`endif
        end
      end
`ifdef ACIA_TX_PARITY_EN
      PARITY: begin
        w_line = r_parity;
        if (w_bit_end) w_state_nxt = STOP;
      end
`endif
      STOP: begin
        w_line = 1'b1;
        if (w_bit_end) begin
          // Back-to-back frames: pop straight into the next start bit
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = START;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Baud counter, shift register and bit index; all restart when a byte is popped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_baud    <= '0;
      r_shift   <= '0;
      r_bit_idx <= '0;
`ifdef ACIA_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else if (w_pop) begin
      r_baud    <= '0;
      r_shift   <= w_fifo_dat;
      r_bit_idx <= '0;
`ifdef ACIA_TX_PARITY_EN
      r_parity  <= ^w_fifo_dat;
`endif
    end else if (r_state == IDLE) begin
      r_baud <= '0;
    end else begin
      r_baud <= w_bit_end ? '0 : r_baud + 1'b1;
      if ((r_state == DATA) && w_bit_end) begin
        r_shift   <= r_shift >> 1;
        r_bit_idx <= r_bit_idx + 1'b1;
      end
    end
  end

  // Registered pin and status flags; busy looks at next-cycle state and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_serial <= LINE_IDLE;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_tx_serial <= w_line;
      r_busy      <= (w_state_nxt != IDLE) | ~w_empty_nxt;
      r_err       <= bus.tx_stb & w_full;
    end
  end

endmodule

// File: tb/tb_acia_tx.sv
// tb/tb_acia_tx.sv - directed self-checking bench for acia_tx (sym_cnt=16, SCW=5, DEPTH=4)
module tb_acia_tx;

`ifdef ACIA_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int SYM       = 16;
  localparam int FRAME_CLK = NB * SYM;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;

  acia_tx_if bus ();

  acia_tx #(.SCW(5), .sym_cnt(SYM), .DEPTH(4)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_byte(input logic [7:0] d);
    bus.tx_dat = d;
    bus.tx_stb = 1'b1;
    @(negedge clk);
    bus.tx_stb = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (bus.tx_busy !== 1'b0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, bus.tx_busy}, 32'd0);
    tick(20);
  endtask

  // Receiver model: elapsed<0 searches for a start bit, otherwise the start began elapsed cycles ago
  task automatic rx_frame(input int elapsed, output logic [7:0] d, output logic p,
                          output logic ok, output int t_start, output logic found);
    int el;
    logic st;
    found = 1'b0;
    el    = elapsed;
    if (elapsed < 0) begin
      el = 0;
      for (int i = 0; i < 2000 && !found; i++) begin
        if (bus.tx_serial === 1'b0) found = 1'b1;
        else @(negedge clk);
      end
    end else begin
      found = 1'b1;
    end
    t_start = cyc - el;
    tick(8 - el);
    st = bus.tx_serial;
    d  = '0;
    for (int k = 0; k < 8; k++) begin
      tick(SYM);
      d[k] = bus.tx_serial;
    end
    p = 1'b0;
`ifdef ACIA_TX_PARITY_EN
    tick(SYM);
    p = bus.tx_serial;
`endif
    tick(SYM);
    ok = (st === 1'b0) && (bus.tx_serial === 1'b1);
  endtask

  initial begin
    logic [NB-1:0] a5_frame;
    logic [7:0]    rd;
    logic          rp, rok, rfound;
    int            t0, t1, bad_line, bad_busy, bad_full;
    logic [7:0]    burst_exp [3];
    logic [7:0]    six_exp [5];
    logic [5:0]    full_exp, err_exp;

`ifdef ACIA_TX_PARITY_EN
    a5_frame = {1'b1, 1'b0, 8'hA5, 1'b0};
`else
    a5_frame = {1'b1, 8'hA5, 1'b0};
`endif
    burst_exp = '{8'h00, 8'hFF, 8'h55};
    six_exp   = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    full_exp  = 6'b110000;
    err_exp   = 6'b100000;

    bus.tx_dat = 8'h00;
    bus.tx_stb = 1'b0;
    rst_n      = 1'b0;
    tick(3);
    chk("reset_serial", {31'd0, bus.tx_serial}, 32'd1);
    chk("reset_busy", {31'd0, bus.tx_busy}, 32'd0);
    chk("reset_full", {31'd0, bus.tx_full}, 32'd0);
    chk("reset_err", {31'd0, bus.tx_err}, 32'd0);
    rst_n = 1'b1;

    // Quiet line after reset release
    bad_line = 0; bad_busy = 0; bad_full = 0;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      if (bus.tx_serial !== 1'b1) bad_line++;
      if (bus.tx_busy !== 1'b0) bad_busy++;
      if (bus.tx_full !== 1'b0) bad_full++;
    end
    chk("idle_line_bad_cycles", bad_line, 0);
    chk("idle_busy_bad_cycles", bad_busy, 0);
    chk("idle_full_bad_cycles", bad_full, 0);

    // Single byte 0xA5, bit-exact waveform
    write_byte(8'hA5);
    chk("a5_busy_after_accept", {31'd0, bus.tx_busy}, 32'd1);
    chk("a5_line_edge0", {31'd0, bus.tx_serial}, 32'd1);
    tick(1);
    chk("a5_line_edge1", {31'd0, bus.tx_serial}, 32'd1);
    tick(1);
    for (int b = 0; b < NB; b++) begin
      chk($sformatf("a5_bit%0d_first", b), {31'd0, bus.tx_serial}, {31'd0, a5_frame[b]});
      if (b == NB - 1) begin
        tick(SYM - 2);
        chk("a5_busy_before_end", {31'd0, bus.tx_busy}, 32'd1);
        tick(1);
        chk("a5_busy_fall", {31'd0, bus.tx_busy}, 32'd0);
        chk($sformatf("a5_bit%0d_last", b), {31'd0, bus.tx_serial}, {31'd0, a5_frame[b]});
        tick(1);
      end else begin
        tick(SYM - 1);
        chk($sformatf("a5_bit%0d_last", b), {31'd0, bus.tx_serial}, {31'd0, a5_frame[b]});
        tick(1);
      end
    end
    chk("a5_line_idle_after", {31'd0, bus.tx_serial}, 32'd1);

    // Burst of three bytes on consecutive cycles, no idle gap between frames
    wait_idle("burst_pre_idle");
    bus.tx_stb = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.tx_dat = burst_exp[i];
      @(negedge clk);
    end
    bus.tx_stb = 1'b0;
    t0 = 0;
    for (int i = 0; i < 3; i++) begin
      rx_frame(-1, rd, rp, rok, t1, rfound);
      chk($sformatf("burst%0d_found", i), {31'd0, rfound}, 32'd1);
      chk($sformatf("burst%0d_data", i), {24'd0, rd}, {24'd0, burst_exp[i]});
      chk($sformatf("burst%0d_framing", i), {31'd0, rok}, 32'd1);
      if (i == 0) t0 = t1;
      else chk($sformatf("burst%0d_start_offset", i), t1 - t0, i * FRAME_CLK);
    end

    // Six writes while idle: one pops, four fill, the sixth is dropped
    wait_idle("six_pre_idle");
    for (int i = 0; i < 6; i++) begin
      bus.tx_dat = 8'((i + 1) * 8'h11);
      bus.tx_stb = 1'b1;
      @(negedge clk);
      chk($sformatf("six_full_w%0d", i), {31'd0, bus.tx_full}, {31'd0, full_exp[i]});
      chk($sformatf("six_err_w%0d", i), {31'd0, bus.tx_err}, {31'd0, err_exp[i]});
    end
    bus.tx_stb = 1'b0;
    tick(1);
    chk("six_err_one_cycle", {31'd0, bus.tx_err}, 32'd0);
    chk("six_full_hold", {31'd0, bus.tx_full}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      rx_frame((i == 0) ? 4 : -1, rd, rp, rok, t1, rfound);
      chk($sformatf("six%0d_found", i), {31'd0, rfound}, 32'd1);
      chk($sformatf("six%0d_data", i), {24'd0, rd}, {24'd0, six_exp[i]});
      chk($sformatf("six%0d_framing", i), {31'd0, rok}, 32'd1);
    end
    bad_line = 0;
    for (int i = 0; i < 2 * FRAME_CLK; i++) begin
      tick(1);
      if (bus.tx_serial !== 1'b1) bad_line++;
    end
    chk("six_no_sixth_frame", bad_line, 0);

    // Reset in the middle of a frame with two more bytes queued
    wait_idle("rst_pre_idle");
    write_byte(8'h3A);
    write_byte(8'h5A);
    write_byte(8'h5A);
    tick(50);
    chk("rst_midframe_line_low", {31'd0, bus.tx_serial}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_line_high", {31'd0, bus.tx_serial}, 32'd1);
    chk("rst_async_busy", {31'd0, bus.tx_busy}, 32'd0);
    chk("rst_async_full", {31'd0, bus.tx_full}, 32'd0);
    tick(3);
    rst_n = 1'b1;
    bad_line = 0; bad_busy = 0;
    for (int i = 0; i < 3 * FRAME_CLK; i++) begin
      tick(1);
      if (bus.tx_serial !== 1'b1) bad_line++;
      if (bus.tx_busy !== 1'b0) bad_busy++;
    end
    chk("rst_after_line_quiet", bad_line, 0);
    chk("rst_after_fifo_empty", bad_busy, 0);

`ifdef ACIA_TX_PARITY_EN
    // Even parity bit and the longer frame
    wait_idle("par_pre_idle");
    bus.tx_stb = 1'b1;
    bus.tx_dat = 8'h07;
    @(negedge clk);
    bus.tx_dat = 8'h03;
    @(negedge clk);
    bus.tx_stb = 1'b0;
    rx_frame(-1, rd, rp, rok, t0, rfound);
    chk("par07_found", {31'd0, rfound}, 32'd1);
    chk("par07_data", {24'd0, rd}, 32'h07);
    chk("par07_parity", {31'd0, rp}, 32'd1);
    chk("par07_framing", {31'd0, rok}, 32'd1);
    rx_frame(-1, rd, rp, rok, t1, rfound);
    chk("par03_found", {31'd0, rfound}, 32'd1);
    chk("par03_data", {24'd0, rd}, 32'h03);
    chk("par03_parity", {31'd0, rp}, 32'd0);
    chk("par03_framing", {31'd0, rok}, 32'd1);
    chk("par_frame_len", t1 - t0, 176);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
